// File: rtl/dm_cache_ctrl_if.sv
// CPU, memory-bus and tag/data-store signals of the direct-mapped cache controller.
// master = the controller, slave = the CPU/memory/store side.
interface dm_cache_ctrl_if #(
  parameter int INDEX_LENGTH = 5,
  parameter int TAG_LENGTH   = 25
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic [31:0]             cpu_addr;
  logic [31:0]             cpu_wdata;
  logic                    cpu_stall;
  logic                    cpu_done;
  logic [31:0]             cpu_rdata;

  logic                    tag_w_en;
  logic [INDEX_LENGTH-1:0] tag_index;
  logic [TAG_LENGTH-1:0]   tag_in;
  logic [TAG_LENGTH-1:0]   tag_out;
  logic                    data_w_en;
  logic [31:0]             data_in;
  logic [31:0]             data_out;

  logic                    mem_req;
  logic                    mem_we;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic                    mem_ready;
  logic [31:0]             mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, tag_out, data_out, mem_ready, mem_rdata,
    output cpu_stall, cpu_done, cpu_rdata, tag_w_en, tag_index, tag_in,
           data_w_en, data_in, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, tag_out, data_out, mem_ready, mem_rdata,
    input  cpu_stall, cpu_done, cpu_rdata, tag_w_en, tag_index, tag_in,
           data_w_en, data_in, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Sequencer for a direct-mapped, one-word-line, write-through, no-write-allocate cache.
// Owns valid bits, CPU/memory handshakes and saturating hit/miss counters.
module dm_cache_ctrl #(
  parameter int INDEX_LENGTH = 5,
  parameter int TAG_LENGTH   = 25,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  dm_cache_ctrl_if.master  bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int CACHE_LINE_NUM = 2 ** INDEX_LENGTH;
  localparam logic [CNT_W-1:0] cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, COMPARE, MISS_RD, WR_THRU} ctrlState_t;

  ctrlState_t                state;
  logic [CACHE_LINE_NUM-1:0] validBits;
  logic [31:0]               addrLat;
  logic                      weLat;
  logic [31:0]               wdataLat;

  logic [TAG_LENGTH-1:0]     latTag;
  logic [INDEX_LENGTH-1:0]   latIndex;
  logic                      hit;

  assign latTag   = addrLat[31:INDEX_LENGTH+2];
  assign latIndex = addrLat[INDEX_LENGTH+1:2];
  assign hit      = validBits[latIndex] && (bus.tag_out == latTag);

  assign bus.cpu_stall = (state != IDLE);
  assign bus.tag_index = latIndex;
  assign bus.mem_addr  = addrLat & 32'hFFFF_FFFC;
  assign bus.mem_wdata = wdataLat;

  // Store enables and the memory request decode straight from state, so a reset
  // drops mem_req in the same instant the state register clears.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    bus.tag_w_en  = 1'b0;
    bus.data_w_en = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.tag_in    = latTag;
    bus.data_in   = wdataLat;
    case (state)
      COMPARE: if (weLat && hit) bus.data_w_en = 1'b1;
      MISS_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.tag_w_en  = 1'b1;
          bus.data_w_en = 1'b1;
          bus.data_in   = bus.mem_rdata;
        end
      end
      WR_THRU: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      // NOTE: valid bits are flops, not store RAM, so clearing them on reset is cheap and is what invalidates the cache.
      validBits     <= '0;
      addrLat       <= '0;
      weLat         <= 1'b0;
      wdataLat      <= '0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_rdata <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      bus.cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            addrLat  <= bus.cpu_addr;
            weLat    <= bus.cpu_we;
            wdataLat <= bus.cpu_wdata;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + cntOne;
            if (weLat) begin
              state <= WR_THRU;
            end else begin
              bus.cpu_rdata <= bus.data_out;
              bus.cpu_done  <= 1'b1;
              state         <= IDLE;
            end
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + cntOne;
            state <= weLat ? WR_THRU : MISS_RD;
          end
        end
        MISS_RD: begin
          if (bus.mem_ready) begin
            validBits[latIndex] <= 1'b1;
            bus.cpu_rdata       <= bus.mem_rdata;
            bus.cpu_done        <= 1'b1;
            state               <= IDLE;
          end
        end
        WR_THRU: begin
          if (bus.mem_ready) begin
            bus.cpu_done <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
